// File: rtl/pwd_lock_pkg.sv
// Shared definitions for the password-lock controller: FSM state encoding,
// special key codes and the digit-range helper.
package pwd_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_ENTRY = 3'd1,
        ST_CHK_ENTRY = 3'd2,
        ST_OPEN      = 3'd3,
        ST_LOCKOUT   = 3'd4
    } state_t;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN window and the LOCKOUT period.
// It holds at zero, and expired_o is high whenever the count is zero.
module lock_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load takes priority over counting down.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Parametrised password-lock FSM with entry editing, attempt limiting,
// a timed unlock window and a timed lockout.
module pwd_lock_ctrl
    import pwd_lock_pkg::*;
#(
    parameter int MAX_LEN        = 6,
    parameter int MAX_TRIES      = 3,
    parameter int OPEN_CYCLES    = 1000,
    parameter int LOCKOUT_CYCLES = 50000,
    parameter int CNT_W          = 16,
    localparam int LEN_W         = $clog2(MAX_LEN + 1),
    localparam int BUF_W         = 4 * MAX_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic                 check,
    input  logic                 confirm,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    output logic                 set_led,
    output logic                 unlock,
    output logic                 locked_out,
    output logic [MAX_TRIES-1:0] ledwrong,
    output logic                 pwd_valid,
    output logic [BUF_W-1:0]     entry_digits,
    output logic [LEN_W-1:0]     entry_len
);

    state_t               state_q, state_d;
    logic [BUF_W-1:0]     buf_q, buf_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [BUF_W-1:0]     pwd_q, pwd_d;
    logic [LEN_W-1:0]     pwd_len_q, pwd_len_d;
    logic                 pwd_valid_q, pwd_valid_d;
    logic [MAX_TRIES-1:0] wrong_q, wrong_d;
    logic                 set_led_q, unlock_q, locked_out_q;

    logic [BUF_W-1:0]     buf_ed_s;
    logic [LEN_W-1:0]     len_ed_s;
    logic [MAX_TRIES-1:0] wrong_inc_s;
    logic                 match_s;
    logic                 tmr_load_s;
    logic [CNT_W-1:0]     tmr_val_s;
    logic                 tmr_exp_s;

    lock_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .expired_o  (tmr_exp_s)
    );

    // Entry buffer after applying this cycle's key, so a same-cycle confirm sees it.
    always_comb begin
        buf_ed_s = buf_q;
        len_ed_s = len_q;
        if (key_valid) begin
            if (is_digit(key_code)) begin
                if (len_q < LEN_W'(MAX_LEN)) begin
                    buf_ed_s = (buf_q << 4) | BUF_W'(key_code);
                    len_ed_s = len_q + LEN_W'(1);
                end else begin
                    buf_ed_s = buf_q;
                end
            end else if (key_code == KEY_BKSP) begin
                if (len_q != {LEN_W{1'b0}}) begin
                    buf_ed_s = buf_q >> 4;
                    len_ed_s = len_q - LEN_W'(1);
                end else begin
                    buf_ed_s = buf_q;
                end
            end else if (key_code == KEY_CLR) begin
                buf_ed_s = {BUF_W{1'b0}};
                len_ed_s = {LEN_W{1'b0}};
            end else begin
                buf_ed_s = buf_q;
            end
        end else begin
            buf_ed_s = buf_q;
        end
    end

    // Wrong count is held as a thermometer, so incrementing is a shift-in of a one.
    always_comb begin
        wrong_inc_s = (wrong_q << 1) | MAX_TRIES'(1);
        match_s     = (len_ed_s == pwd_len_q) && (buf_ed_s == pwd_q);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        len_d       = len_q;
        pwd_d       = pwd_q;
        pwd_len_d   = pwd_len_q;
        pwd_valid_d = pwd_valid_q;
        wrong_d     = wrong_q;
        tmr_load_s  = 1'b0;
        tmr_val_s   = {CNT_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (set && !pwd_valid_q) begin
                    state_d = ST_SET_ENTRY;
                    buf_d   = {BUF_W{1'b0}};
                    len_d   = {LEN_W{1'b0}};
                end else if (check && pwd_valid_q) begin
                    state_d = ST_CHK_ENTRY;
                    buf_d   = {BUF_W{1'b0}};
                    len_d   = {LEN_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SET_ENTRY: begin
                buf_d = buf_ed_s;
                len_d = len_ed_s;
                if (confirm && (len_ed_s != {LEN_W{1'b0}})) begin
                    pwd_d       = buf_ed_s;
                    pwd_len_d   = len_ed_s;
                    pwd_valid_d = 1'b1;
                    wrong_d     = {MAX_TRIES{1'b0}};
                    buf_d       = {BUF_W{1'b0}};
                    len_d       = {LEN_W{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_SET_ENTRY;
                end
            end

            ST_CHK_ENTRY: begin
                buf_d = buf_ed_s;
                len_d = len_ed_s;
                if (confirm) begin
                    buf_d = {BUF_W{1'b0}};
                    len_d = {LEN_W{1'b0}};
                    if (match_s) begin
                        wrong_d    = {MAX_TRIES{1'b0}};
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_W'(OPEN_CYCLES - 1);
                        state_d    = ST_OPEN;
                    end else if (wrong_inc_s[MAX_TRIES-1]) begin
                        wrong_d    = wrong_inc_s;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_W'(LOCKOUT_CYCLES - 1);
                        state_d    = ST_LOCKOUT;
                    end else begin
                        wrong_d = wrong_inc_s;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CHK_ENTRY;
                end
            end

            // Re-programming is only reachable from here; it beats a same-cycle expiry.
            ST_OPEN: begin
                if (set) begin
                    state_d = ST_SET_ENTRY;
                    buf_d   = {BUF_W{1'b0}};
                    len_d   = {LEN_W{1'b0}};
                end else if (tmr_exp_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OPEN;
                end
            end

            ST_LOCKOUT: begin
                if (tmr_exp_s) begin
                    wrong_d = {MAX_TRIES{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                buf_d   = {BUF_W{1'b0}};
                len_d   = {LEN_W{1'b0}};
            end
        endcase
    end

    // State, datapath and status-output registers; status flags decode the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            buf_q        <= {BUF_W{1'b0}};
            len_q        <= {LEN_W{1'b0}};
            pwd_q        <= {BUF_W{1'b0}};
            pwd_len_q    <= {LEN_W{1'b0}};
            pwd_valid_q  <= 1'b0;
            wrong_q      <= {MAX_TRIES{1'b0}};
            set_led_q    <= 1'b0;
            unlock_q     <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            pwd_q        <= pwd_d;
            pwd_len_q    <= pwd_len_d;
            pwd_valid_q  <= pwd_valid_d;
            wrong_q      <= wrong_d;
            set_led_q    <= (state_d == ST_SET_ENTRY);
            unlock_q     <= (state_d == ST_OPEN);
            locked_out_q <= (state_d == ST_LOCKOUT);
        end
    end

    assign set_led      = set_led_q;
    assign unlock       = unlock_q;
    assign locked_out   = locked_out_q;
    assign ledwrong     = wrong_q;
    assign pwd_valid    = pwd_valid_q;
    assign entry_digits = buf_q;
    assign entry_len    = len_q;

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Directed self-checking bench for pwd_lock_ctrl with shortened timer lengths.
module tb_pwd_lock_ctrl;

    localparam int MAX_LEN = 6;
    localparam int MAX_TRIES = 3;
    localparam int OPEN_C = 20;
    localparam int LOCK_C = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0, check = 1'b0, confirm = 1'b0, key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        set_led, unlock, locked_out, pwd_valid;
    logic [2:0]  ledwrong;
    logic [23:0] entry_digits;
    logic [2:0]  entry_len;

    int checks = 0;
    int passed = 0;

    pwd_lock_ctrl #(
        .MAX_LEN(MAX_LEN), .MAX_TRIES(MAX_TRIES), .OPEN_CYCLES(OPEN_C),
        .LOCKOUT_CYCLES(LOCK_C), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .check(check), .confirm(confirm),
        .key_valid(key_valid), .key_code(key_code), .set_led(set_led),
        .unlock(unlock), .locked_out(locked_out), .ledwrong(ledwrong),
        .pwd_valid(pwd_valid), .entry_digits(entry_digits), .entry_len(entry_len)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: drive for one cycle between falling edges.
    task automatic p_set();     @(negedge clk); set = 1'b1;     @(negedge clk); set = 1'b0;     endtask
    task automatic p_check();   @(negedge clk); check = 1'b1;   @(negedge clk); check = 1'b0;   endtask
    task automatic p_confirm(); @(negedge clk); confirm = 1'b1; @(negedge clk); confirm = 1'b0; endtask
    task automatic p_key(input logic [3:0] k);
        @(negedge clk); key_valid = 1'b1; key_code = k;
        @(negedge clk); key_valid = 1'b0;
    endtask
    task automatic p_key_confirm(input logic [3:0] k);
        @(negedge clk); key_valid = 1'b1; key_code = k; confirm = 1'b1;
        @(negedge clk); key_valid = 1'b0; confirm = 1'b0;
    endtask
    task automatic enter_123();
        p_key(4'd1); p_key(4'd2); p_key(4'd3);
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((unlock || locked_out) && n < 1000) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({set_led, unlock, locked_out, pwd_valid} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {set_led, unlock, locked_out, pwd_valid}); else passed++;
        checks++; if ({ledwrong, entry_len, entry_digits} !== 30'd0) $display("FAIL reset_data: got %h expected 0", {ledwrong, entry_len, entry_digits}); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_program();
        p_check();
        checks++; if (entry_len !== 3'd0 || set_led !== 1'b0) $display("FAIL check_without_pwd: got len %0d set_led %b expected 0 0", entry_len, set_led); else passed++;
        p_set();
        checks++; if (set_led !== 1'b1) $display("FAIL set_led_on: got %b expected 1", set_led); else passed++;
        enter_123();
        checks++; if (entry_len !== 3'd3 || entry_digits !== 24'h000123) $display("FAIL set_entry: got %0d/%h expected 3/000123", entry_len, entry_digits); else passed++;
        p_confirm();
        checks++; if ({pwd_valid, set_led, entry_len} !== 5'b10000) $display("FAIL program_done: got %b expected 10000", {pwd_valid, set_led, entry_len}); else passed++;
    endtask

    task automatic test_unlock();
        int n = 0;
        p_check(); enter_123(); p_confirm();
        checks++; if (unlock !== 1'b1 || ledwrong !== 3'b000) $display("FAIL unlock_on: got %b/%b expected 1/000", unlock, ledwrong); else passed++;
        while (unlock && n < 1000) begin n++; @(negedge clk); end
        checks++; if (n !== OPEN_C) $display("FAIL open_length: got %0d expected %0d", n, OPEN_C); else passed++;
    endtask

    task automatic test_wrong();
        p_check(); p_key(4'd5); p_key(4'd4); p_key(4'd3); p_confirm();
        checks++; if (ledwrong !== 3'b001 || unlock !== 1'b0) $display("FAIL wrong_1: got %b/%b expected 001/0", ledwrong, unlock); else passed++;
        p_check(); p_key(4'd1); p_key(4'd2); p_confirm();
        checks++; if (ledwrong !== 3'b011 || unlock !== 1'b0) $display("FAIL wrong_short: got %b/%b expected 011/0", ledwrong, unlock); else passed++;
    endtask

    task automatic test_lockout();
        int n = 0;
        p_check(); p_key(4'd9); p_confirm();
        checks++; if (locked_out !== 1'b1 || ledwrong !== 3'b111) $display("FAIL lockout_on: got %b/%b expected 1/111", locked_out, ledwrong); else passed++;
        while (locked_out && n < 1000) begin
            n++;
            check = (n == 3); key_valid = (n == 5); key_code = 4'd1; confirm = (n == 7);
            @(negedge clk);
            if (n == 8) begin
                checks++; if (entry_len !== 3'd0 || ledwrong !== 3'b111 || set_led !== 1'b0) $display("FAIL lockout_ignore: got len %0d led %b expected 0 111", entry_len, ledwrong); else passed++;
            end
        end
        check = 1'b0; key_valid = 1'b0; confirm = 1'b0;
        checks++; if (n !== LOCK_C) $display("FAIL lockout_length: got %0d expected %0d", n, LOCK_C); else passed++;
        checks++; if (ledwrong !== 3'b000) $display("FAIL lockout_clear: got %b expected 000", ledwrong); else passed++;
        p_check(); enter_123(); p_confirm();
        checks++; if (unlock !== 1'b1) $display("FAIL unlock_after_lockout: got %b expected 1", unlock); else passed++;
        wait_idle();
    endtask

    task automatic test_editing();
        p_check(); p_key(4'd1); p_key(4'd2); p_key(4'd9); p_key(4'hA);
        checks++; if (entry_len !== 3'd2 || entry_digits !== 24'h000012) $display("FAIL backspace: got %0d/%h expected 2/000012", entry_len, entry_digits); else passed++;
        p_key(4'd3); p_confirm();
        checks++; if (unlock !== 1'b1) $display("FAIL edited_unlock: got %b expected 1", unlock); else passed++;
        wait_idle();
        p_check();
        for (int d = 1; d <= MAX_LEN + 2; d++) p_key(4'(d));
        checks++; if (entry_len !== 3'd6 || entry_digits !== 24'h123456) $display("FAIL saturate: got %0d/%h expected 6/123456", entry_len, entry_digits); else passed++;
        p_key(4'hB);
        checks++; if (entry_len !== 3'd0 || entry_digits !== 24'h0) $display("FAIL clear: got %0d/%h expected 0/000000", entry_len, entry_digits); else passed++;
        p_confirm();
        checks++; if (ledwrong !== 3'b001 || unlock !== 1'b0) $display("FAIL empty_check: got %b/%b expected 001/0", ledwrong, unlock); else passed++;
    endtask

    task automatic test_guards();
        p_set();
        checks++; if (set_led !== 1'b0) $display("FAIL set_ignored: got %b expected 0", set_led); else passed++;
        p_check(); enter_123(); p_confirm();
        checks++; if (unlock !== 1'b1 || ledwrong !== 3'b000) $display("FAIL reopen: got %b/%b expected 1/000", unlock, ledwrong); else passed++;
        p_set();
        checks++; if (set_led !== 1'b1 || unlock !== 1'b0) $display("FAIL set_in_open: got %b/%b expected 1/0", set_led, unlock); else passed++;
        p_key(4'd7); p_key(4'd7); p_confirm();
        checks++; if (set_led !== 1'b0 || pwd_valid !== 1'b1) $display("FAIL reprogram: got %b/%b expected 0/1", set_led, pwd_valid); else passed++;
        p_check(); p_key(4'd7); p_key(4'd7); p_confirm();
        checks++; if (unlock !== 1'b1) $display("FAIL new_pwd: got %b expected 1", unlock); else passed++;
        wait_idle();
        p_check(); enter_123(); p_confirm();
        checks++; if (unlock !== 1'b0 || ledwrong !== 3'b001) $display("FAIL old_pwd: got %b/%b expected 0/001", unlock, ledwrong); else passed++;
    endtask

    task automatic test_back_to_back();
        p_check(); p_key(4'd7); p_key_confirm(4'd7);
        checks++; if (unlock !== 1'b1 || ledwrong !== 3'b000 || entry_len !== 3'd0) $display("FAIL key_with_confirm: got %b/%b/%0d expected 1/000/0", unlock, ledwrong, entry_len); else passed++;
        wait_idle();
    endtask

    task automatic test_reset_lockout();
        for (int i = 0; i < MAX_TRIES; i++) begin p_check(); p_key(4'd1); p_confirm(); end
        checks++; if (locked_out !== 1'b1) $display("FAIL reach_lockout: got %b expected 1", locked_out); else passed++;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({set_led, unlock, locked_out, pwd_valid, ledwrong, entry_len} !== 10'd0) $display("FAIL async_reset: got %b expected 0", {set_led, unlock, locked_out, pwd_valid, ledwrong, entry_len}); else passed++;
        @(negedge clk); rst = 1'b0;
        p_set();
        checks++; if (set_led !== 1'b1 || pwd_valid !== 1'b0) $display("FAIL set_after_reset: got %b/%b expected 1/0", set_led, pwd_valid); else passed++;
        p_confirm();
        checks++; if (set_led !== 1'b1 || pwd_valid !== 1'b0) $display("FAIL empty_set_confirm: got %b/%b expected 1/0", set_led, pwd_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_unlock();
        test_wrong();
        test_lockout();
        test_editing();
        test_guards();
        test_back_to_back();
        test_reset_lockout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwd_lock_ctrl.md
Name: pwd_lock_ctrl

Overview:
- Parametrised password-lock core FSM, successor to the fixed 3-digit / 3-try lock controller.
- Sits between the keypad scanner/debouncer, which supplies single-cycle key and button pulses, and the LED / 7-segment display drivers.
- Adds configurable password length, configurable attempt limit, timed unlock window, timed lockout, and backspace/clear editing.

Parameters:
- MAX_LEN, 6: maximum password digits (1..8).
- MAX_TRIES, 3: consecutive wrong attempts before lockout (1..8).
- OPEN_CYCLES, 1000: clk cycles the unlock output stays high.
- LOCKOUT_CYCLES, 50000: clk cycles of lockout.
- CNT_W, 16: timer width; must hold max(OPEN_CYCLES, LOCKOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- set  in  1  single-cycle pulse: request password programming
- check  in  1  single-cycle pulse: request verification
- confirm  in  1  single-cycle pulse: end current entry
- key_valid  in  1  single-cycle pulse: key_code is valid
- key_code  in  4  0-9 digit, 'hA backspace, 'hB clear, others ignored
- set_led  out  1  high in SET_ENTRY
- unlock  out  1  high in OPEN
- locked_out  out  1  high in LOCKOUT
- ledwrong  out  MAX_TRIES  thermometer of wrong-attempt count
- pwd_valid  out  1  a password has been stored since reset
- entry_digits  out  4*MAX_LEN  current entry; newest digit at [3:0]
- entry_len  out  $clog2(MAX_LEN+1)  digits currently entered

Behaviour:
- Reset: asynchronous, active-high.
  - State to IDLE; all outputs 0; stored password, stored length, wrong count and timer cleared.
- States: IDLE, SET_ENTRY, CHK_ENTRY, OPEN, LOCKOUT. All outputs are registered, 1-cycle latency after the causing pulse.
- IDLE:
  - set goes to SET_ENTRY only if pwd_valid=0.
  - check goes to CHK_ENTRY only if pwd_valid=1.
  - If set and check arrive together, set wins when legal. All other inputs are ignored.
  - Entering SET_ENTRY or CHK_ENTRY clears the entry buffer and entry_len.
- OPEN:
  - set goes to SET_ENTRY (re-programming is allowed only while unlocked).
  - Timer expiry goes to IDLE.
- Entry editing (SET_ENTRY and CHK_ENTRY):
  - Digit with entry_len<MAX_LEN: shift the buffer left 4 bits, insert the digit, entry_len+1.
  - Digit at MAX_LEN: ignored.
  - Backspace: shift right 4 bits, zero-fill the top nibble, entry_len-1. Ignored at 0.
  - Clear: buffer and entry_len set to 0.
  - If key_valid and confirm arrive in the same cycle, the key is applied first and compare/store uses the updated entry.
- SET_ENTRY + confirm:
  - entry_len=0: ignored, stay.
  - Otherwise store buffer and length, pwd_valid=1, wrong count=0, go to IDLE.
- CHK_ENTRY + confirm:
  - Match requires equal length AND equal digits.
  - Match: wrong count=0, load timer with OPEN_CYCLES-1, go to OPEN.
  - Mismatch: wrong count+1. If it reaches MAX_TRIES, load timer with LOCKOUT_CYCLES-1 and go to LOCKOUT; otherwise go to IDLE.
  - Every confirm clears the entry buffer.
- LOCKOUT:
  - All inputs ignored; ledwrong stays all-ones.
  - On timer expiry: wrong count=0, go to IDLE.
- Timer: down-counter; "expiry" is the cycle where the count is 0. OPEN and LOCKOUT therefore last exactly OPEN_CYCLES and LOCKOUT_CYCLES cycles.
- ledwrong[i] = (wrong count > i).
- Reset mid-operation (any state, including LOCKOUT) gives full reset; the stored password is lost.

Decomposition:
- Shared package pwd_lock_pkg:
  - State enum.
  - Key-code constants KEY_BKSP='hA and KEY_CLR='hB.
  - Digit-range check function.
- One sub-module, lock_timer: loadable CNT_W down-counter with load, load value, and expired flag. It is shared by OPEN and LOCKOUT.

Test Plan:
1. rst, then set, keys 1,2,3, confirm -> pwd_valid=1, set_led 1 then 0, state IDLE, entry_len=0.
2. check, keys 1,2,3, confirm -> unlock=1 for exactly OPEN_CYCLES cycles, ledwrong=000.
3. check with 5,4,3; then check with 1,2 (shorter entry) -> ledwrong=001 then 011, unlock stays 0.
4. Third wrong entry -> locked_out=1, ledwrong=111; check/key pulses during lockout are ignored; after LOCKOUT_CYCLES cycles, IDLE with ledwrong=000; correct 1,2,3 then unlocks.
5. Editing: check, keys 1,2,9,BKSP,3, confirm -> match and unlock. MAX_LEN+2 digits -> entry_len saturates at MAX_LEN. CLR -> entry_len=0.
6. Guards:
   - set in IDLE with pwd_valid=1 -> ignored.
   - set during OPEN, keys 7,7, confirm -> new password stored; check 7,7 unlocks, check 1,2,3 fails.
   - rst asserted mid-LOCKOUT -> all outputs 0 immediately.
